// File: rtl/uart_vga_pkg.sv
// Shared constants and state type for the UART bit-display RAM write side.
package uart_vga_pkg;

    localparam int unsigned UART_VGA_ROW_BYTES = 20;
    localparam int unsigned UART_VGA_ROWS      = 64;
    localparam int unsigned UART_VGA_RAM_BYTES = 1280;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } uart_vga_wr_state_t;

    // Row start address: row*20 built from shifts so it stays adder-only.
    function automatic logic [10:0] row_base(input logic [5:0] row);
        logic [10:0] r;
        r = {5'b0, row};
        return (r << 4) + (r << 2);
    endfunction

endpackage

// File: rtl/uart_vga_writer.sv
// UART byte stream to display-RAM write port, with row/screen cursor.
// Optional full-RAM zero fill is compiled in with UART_VGA_WRITER_CLEAR_EN.
module uart_vga_writer
    import uart_vga_pkg::*;
#(
    parameter int unsigned ROW_BYTES = UART_VGA_ROW_BYTES,
    parameter int unsigned ROWS      = UART_VGA_ROWS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        clear_req,
    output logic        busy,
    output logic [31:0] write_address,
    output logic [7:0]  ram_in,
    output logic        we,
    output logic [5:0]  cursor_row,
    output logic [4:0]  cursor_byte
);

    localparam logic [4:0] LAST_BYTE = 5'(ROW_BYTES - 1);
    localparam logic [5:0] LAST_ROW  = 6'(ROWS - 1);

    logic        accept;
    logic [10:0] cursor_addr;
    logic [5:0]  adv_row;
    logic [4:0]  adv_byte;

    logic        we_n;
    logic [7:0]  ram_in_n;
    logic [31:0] addr_n;
    logic [5:0]  row_n;
    logic [4:0]  byte_n;

    assign cursor_addr = row_base(cursor_row) + {6'b0, cursor_byte};

`ifdef UART_VGA_WRITER_CLEAR_EN
    localparam logic [10:0] SWEEP_END = 11'(UART_VGA_RAM_BYTES);

    uart_vga_wr_state_t state, state_n;
    logic [10:0]        sweep, sweep_n;

    assign in_ready = (state == RUN) && !clear_req;
    assign busy     = (state == CLEAR);
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign in_ready         = 1'b1;
    assign busy             = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    // Cursor position after an accepted byte; in_last forces the home position.
    always_comb begin
        adv_row  = cursor_row;
        adv_byte = cursor_byte;
        if (in_last) begin
            adv_row  = '0;
            adv_byte = '0;
        end else if (cursor_byte == LAST_BYTE) begin
            adv_byte = '0;
            adv_row  = (cursor_row == LAST_ROW) ? '0 : cursor_row + 6'd1;
        end else begin
            adv_byte = cursor_byte + 5'd1;
        end
    end

    // Next-state and next-output selection for byte writes and the clear sweep.
    always_comb begin
        we_n     = 1'b0;
        ram_in_n = ram_in;
        addr_n   = write_address;
        row_n    = cursor_row;
        byte_n   = cursor_byte;
`ifdef UART_VGA_WRITER_CLEAR_EN
        state_n  = state;
        sweep_n  = sweep;
`endif

        if (accept) begin
            we_n     = 1'b1;
            ram_in_n = in_data;
            addr_n   = {21'b0, cursor_addr};
            row_n    = adv_row;
            byte_n   = adv_byte;
        end

`ifdef UART_VGA_WRITER_CLEAR_EN
        // Entry from RUN already issues address 0, so the counter starts at 1;
        // after reset it starts at 0 with no write pending.
        case (state)
            RUN: begin
                if (clear_req) begin
                    state_n  = CLEAR;
                    we_n     = 1'b1;
                    ram_in_n = '0;
                    addr_n   = '0;
                    sweep_n  = 11'd1;
                end
            end
            CLEAR: begin
                if (sweep == SWEEP_END) begin
                    state_n = RUN;
                    row_n   = '0;
                    byte_n  = '0;
                end else begin
                    we_n     = 1'b1;
                    ram_in_n = '0;
                    addr_n   = {21'b0, sweep};
                    sweep_n  = sweep + 11'd1;
                end
            end
            default: state_n = RUN;
        endcase
`endif
    end

`ifdef UART_VGA_WRITER_CLEAR_EN
    // FSM state and sweep counter; reset restarts a full zero fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            sweep <= '0;
        end else begin
            state <= state_n;
            sweep <= sweep_n;
        end
    end
`endif

    // Registered RAM write port and cursor.
    always_ff @(posedge clk) begin
        if (rst) begin
            we            <= 1'b0;
            ram_in        <= '0;
            write_address <= '0;
            cursor_row    <= '0;
            cursor_byte   <= '0;
        end else begin
            we            <= we_n;
            ram_in        <= ram_in_n;
            write_address <= addr_n;
            cursor_row    <= row_n;
            cursor_byte   <= byte_n;
        end
    end

endmodule
